data_memory: RTL



---
 rtl/data_memory_pkg.sv | 30 +++
 rtl/data_memory_array.sv | 38 +++
 rtl/data_memory.sv | 130 +++++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// Shared constants, FSM state type and request payload for the block data memory.
// Optional feature macro: DATA_MEMORY_BYTE_MASK_EN (byte-masked writes).
package data_memory_pkg;

   localparam int unsigned WORD_BITS       = 32;
   localparam int unsigned WORDS_PER_BLOCK = 8;
   localparam int unsigned BLOCK_BITS      = WORDS_PER_BLOCK * WORD_BITS;
   localparam int unsigned BYTES_PER_BLOCK = BLOCK_BITS / 8;
   localparam int unsigned OFFSET_BITS     = 5;
   localparam int unsigned ADDR_BITS       = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Operands captured when a request is accepted
   typedef struct packed {
      logic                       wr;
      logic [BYTES_PER_BLOCK-1:0] be;
      logic [BLOCK_BITS-1:0]      data;
   } req_t;

   // Width needed to hold values 0..n-1 (at least one bit)
   function automatic int unsigned idx_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/data_memory_array.sv
// Block storage: synchronous byte-enabled write port, registered read port, no reset.
module data_memory_array
   import data_memory_pkg::*;
#(
   parameter int unsigned DEPTH_BLOCKS = 64,
   parameter int unsigned IDX_W        = 6
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [IDX_W-1:0]           wr_idx,
   input  logic [BLOCK_BITS-1:0]      wr_data,
   input  logic [BYTES_PER_BLOCK-1:0] wr_be,
   input  logic                       rd_en,
   input  logic [IDX_W-1:0]           rd_idx,
   output logic [BLOCK_BITS-1:0]      rd_data
);

   logic [BLOCK_BITS-1:0] mem [DEPTH_BLOCKS];

   // Write only the enabled bytes of the addressed block
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < int'(BYTES_PER_BLOCK); b++) begin
            if (wr_be[b]) begin
               mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end
   end

   // Registered read, held between enabled reads
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_idx];
      end
   end

endmodule

// File: rtl/data_memory.sv
// Block-oriented data memory behind the data cache with a fixed busywait latency.
// Optional feature macro: DATA_MEMORY_BYTE_MASK_EN adds mem_byteen for byte-masked writes.
module data_memory
   import data_memory_pkg::*;
#(
   parameter int unsigned DEPTH_BLOCKS = 64,
   parameter int unsigned LATENCY      = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       mem_read,
   input  logic                       mem_write,
   input  logic [ADDR_BITS-1:0]       mem_address,
   input  logic [BLOCK_BITS-1:0]      mem_writedata,
`ifdef DATA_MEMORY_BYTE_MASK_EN
   input  logic [BYTES_PER_BLOCK-1:0] mem_byteen,
`endif
   output logic [BLOCK_BITS-1:0]      mem_readdata,
   output logic                       mem_busywait
);

   localparam int unsigned IDX_W = idx_bits(DEPTH_BLOCKS);
   localparam int unsigned CNT_W = idx_bits(LATENCY);

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q;
   logic [IDX_W-1:0]           idx_q;
   logic [IDX_W-1:0]           req_idx_c;
   logic [BYTES_PER_BLOCK-1:0] req_be_c;
   req_t                       req_c;
   req_t                       cap_q;
   logic                       accept_c;
   logic                       finish_c;
   logic [BLOCK_BITS-1:0]      arr_rd_data;
   logic                       unused_offset;

   // Byte offset within a block does not select anything
   assign unused_offset = ^mem_address[OFFSET_BITS-1:0];

   // Out-of-range block numbers wrap onto the array
   assign req_idx_c = IDX_W'(mem_address[ADDR_BITS-1:OFFSET_BITS] % DEPTH_BLOCKS);

`ifdef DATA_MEMORY_BYTE_MASK_EN
   assign req_be_c = mem_byteen;
`else
   assign req_be_c = '1;
`endif

   // Write wins when both read and write are requested
   assign req_c = '{wr: mem_write, be: req_be_c, data: mem_writedata};

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, busywait and access strobes
   always_comb begin
      state_d      = state_q;
      mem_busywait = 1'b0;
      accept_c     = 1'b0;
      finish_c     = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               mem_busywait = 1'b1;
               accept_c     = 1'b1;
               state_d      = BUSY;
            end
         end
         BUSY: begin
            mem_busywait = 1'b1;
            if (cnt_q == '0) begin
               finish_c = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Capture operands on acceptance and count down the remaining busy cycles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         idx_q <= '0;
         cap_q <= '0;
      end else if (accept_c) begin
         cnt_q <= CNT_W'(LATENCY - 2);
         idx_q <= req_idx_c;
         cap_q <= req_c;
      end else if ((state_q == BUSY) && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Read result becomes visible on entry to DONE and holds until the next read completes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_readdata <= '0;
      end else if (finish_c && !cap_q.wr) begin
         mem_readdata <= arr_rd_data;
      end
   end

   // The array is read at acceptance; no write can land on it before the access finishes
   data_memory_array #(
      .DEPTH_BLOCKS (DEPTH_BLOCKS),
      .IDX_W        (IDX_W)
   ) u_array (
      .clk     (clk),
      .wr_en   (finish_c && cap_q.wr),
      .wr_idx  (idx_q),
      .wr_data (cap_q.data),
      .wr_be   (cap_q.be),
      .rd_en   (accept_c && !mem_write),
      .rd_idx  (req_idx_c),
      .rd_data (arr_rd_data)
   );

endmodule
